win_avg_filter: RTL
===================

// Module: win_avg_filter
// PURPOSE
//  Parametrised windowed averager: consumes req-qualified samples from the upstream producer and
//  emits the mean of N = 2**LOG2N accepted samples. Two run-time modes: BLOCK (one result per N
//  samples, non-overlapping) and SLIDING (moving average of the last N samples, one result per
//  sample once the window is full). Sits directly downstream of the sample producer in the clk_2 domain.
// PARAMETERS
//  DW     4  sample and average width, unsigned; >=1
//  LOG2N  2  log2 of window length N; 1..8
//  AW     DW+LOG2N (localparam)  accumulator width; sum of N max samples never overflows
// PORTS
//  clk_2    in   1      clock; every register is on posedge clk_2
//  rst      in   1      asynchronous, active-high reset
//  clr      in   1      synchronous flush: window, accumulator and count to empty
//  mode     in   1      0 = BLOCK, 1 = SLIDING
//  req      in   1      data valid; sample accepted on every clk_2 edge with req=1 (no backpressure)
//  data     in   DW     unsigned sample
//  avg      out  DW     registered average, held between updates
//  avg_vld  out  1      one-cycle pulse, high in the cycle avg carries a new result
//  fill     out  LOG2N+1  number of samples currently counted in the window (0..N)
// BEHAVIOUR
//  - Reset: state=IDLE, acc=0, window buffer all 0, wr_ptr=0, fill=0, avg=0, avg_vld=0, mode_q=0.
//  - Accepted sample: req=1 and clr=0 and no mode change that cycle. Cycles with req=0 change nothing.
//    avg_vld drops to 0.
//  - Latency: the result for the sample accepted at edge k is on avg/avg_vld after edge k (1 cycle).
//  - FSM (state register in clk_2):
//    IDLE: fill=0. Accepted sample -> FILL, mode_q<=mode, fill=1.
//    FILL: each accepted sample fill++. Sample that makes fill reach N -> produce result;
//          BLOCK -> IDLE (acc=0, fill=0); SLIDING -> RUN (fill stays N).
//    RUN (SLIDING only): each accepted sample produces a result; fill stays N.
//  - BLOCK arithmetic: acc <= acc + data; at Nth sample result = (acc+data) >> LOG2N, then acc <= 0.
//  - SLIDING arithmetic: N-entry buffer, wr_ptr wraps N-1 -> 0. On accept:
//    acc <= acc + data - buf[wr_ptr]; buf[wr_ptr] <= data; wr_ptr++.
//    Buffer entries are 0 while filling, so the same update applies in FILL.
//  - Width: acc is AW bits unsigned and never overflows or underflows. The result is AW bits and is
//    truncated to DW bits; it is always <= 2**DW-1.
//  - Mode change: mode != mode_q while not in IDLE -> flush to IDLE next edge (as clr). The sample
//    on that edge is discarded and no result is produced.
//  - clr=1: highest priority after rst. It forces IDLE, acc=0, buf=0, wr_ptr=0, fill=0 and
//    avg_vld=0. avg keeps its last value. A simultaneous req sample is discarded.
//  - rst mid-operation: immediate return to reset values. A partial window is lost with no output.
//  - avg is only written when avg_vld is asserted.
// CONFIGURATION
//  ROUND_EN  defined: result = (sum + N/2) >> LOG2N (round half up). It cannot exceed 2**DW-1,
//            because the floor keeps it in range.
//            undefined: result = sum >> LOG2N (truncate). The add and its logic are absent.
// TESTING (DW=4, LOG2N=2)
//  1 BLOCK: req on 1,2,3,4 -> avg=2 (ROUND_EN: 3), avg_vld 1 cycle; fill 1,2,3,4->0; next 4 start anew.
//  2 SLIDING: 4,8,12,15 -> avg=9 (ROUND_EN 10). Then 15 -> avg=12 (ROUND_EN 13).
//    Then 0 -> avg=10 (ROUND_EN 11). One avg_vld per sample after fill.
//  3 Max/gaps: 15 x4 with req=0 gaps of 0..3 cycles between samples -> avg=15 both configs.
//    No avg_vld during gaps.
//  4 clr at fill=3 with req=1 and data=9 -> fill=0, no avg_vld, avg unchanged.
//    Then 1,1,1,1 -> avg=1.
//  5 mode toggled in RUN -> flush, fill=0. Next 4 samples follow the new mode from IDLE.
//  6 rst asserted mid-FILL and mid-RUN -> avg=0, avg_vld=0, fill=0 asynchronously.
//    Release then 2,2,2,2 -> avg=2.

Source files
------------

// File: rtl/win_avg_filter.sv
// Windowed averager: BLOCK (one mean per N samples) or SLIDING (moving mean) over N = 2**LOG2N samples.
// Optional ROUND_EN macro selects round-half-up instead of truncation for the result.
module win_avg_filter #(
  parameter int DW    = 4,
  parameter int LOG2N = 2
) (
  input  logic             clk_2,
  input  logic             rst,
  input  logic             clr,
  input  logic             mode,
  input  logic             req,
  input  logic [DW-1:0]    data,
  output logic [DW-1:0]    avg,
  output logic             avg_vld,
  output logic [LOG2N:0]   fill
);

  localparam int AW = DW + LOG2N;
  localparam int N  = 1 << LOG2N;
  localparam int FW = LOG2N + 1;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t              state;
  logic                mode_q;
  logic [AW-1:0]       acc;
  logic [LOG2N-1:0]    wr_ptr;
  logic [DW-1:0]       win_buf [N];

  logic                mode_chg;
  logic                eff_mode;
  logic                last;
  logic [AW-1:0]       sum_blk;
  logic [AW-1:0]       sum_sld;
  logic [AW-1:0]       sum;
  logic [DW-1:0]       res;

  always_comb begin
    mode_chg = (state != IDLE) && (mode != mode_q);
    eff_mode = (state == IDLE) ? mode : mode_q;
    last     = (fill == FW'(N - 1));
    sum_blk  = acc + AW'(data);
    // Modular AW-bit arithmetic: the add may wrap transiently, the subtract brings it back in range.
    sum_sld  = acc + AW'(data) - AW'(win_buf[wr_ptr]);
    sum      = eff_mode ? sum_sld : sum_blk;
`ifdef ROUND_EN
    res      = DW'((sum + AW'(N / 2)) >> LOG2N);
`else
    res      = DW'(sum >> LOG2N);
`endif
  end

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mode_q  <= 1'b0;
      acc     <= '0;
      wr_ptr  <= '0;
      fill    <= '0;
      avg     <= '0;
      avg_vld <= 1'b0;
      for (int unsigned i = 0; i < N; i++) win_buf[i] <= '0;
    end else if (clr || mode_chg) begin
      state   <= IDLE;
      acc     <= '0;
      wr_ptr  <= '0;
      fill    <= '0;
      avg_vld <= 1'b0;
      for (int unsigned i = 0; i < N; i++) win_buf[i] <= '0;
    end else begin
      avg_vld <= 1'b0;
      if (req) begin
        if (state == IDLE) mode_q <= mode;
        if (eff_mode) begin
          acc             <= sum_sld;
          win_buf[wr_ptr] <= data;
          wr_ptr          <= wr_ptr + 1'b1;
        end else begin
          acc <= (last && state != RUN) ? '0 : sum_blk;
        end
        if (state == RUN) begin
          avg     <= res;
          avg_vld <= 1'b1;
        end else if (last) begin
          avg     <= res;
          avg_vld <= 1'b1;
          if (eff_mode) begin
            state <= RUN;
            fill  <= fill + 1'b1;
          end else begin
            state <= IDLE;
            fill  <= '0;
          end
        end else begin
          state <= FILL;
          fill  <= fill + 1'b1;
        end
      end
    end
  end

endmodule
